fpu_ret_collect: RTL and testbench

Completion collector on the far side of the three FPU return ports. Accepts per-lane `ret`/`ret_en` results and 11-bit raise flags from FPU lanes 1, 3 and 5, buffers each lane in a small FIFO, and drains them one per cycle to the retire unit over a valid/ready handshake. Accumulates sticky FP exception flags for the fpcsr, and returns per-lane stall back-pressure to the FPU issue side.

---
 rtl/fpu_ret_pkg.sv | 26 ++
 rtl/fpu_ret_fifo.sv | 52 +++++
 rtl/fpu_ret_collect.sv | 128 ++++++++++++
 tb/tb_fpu_ret_collect.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ret_pkg.sv
// Shared types and constants for the FPU completion collector.
// Lane indices, entry layout and the round-robin successor helper.
package fpu_ret_pkg;

  localparam int RAISE_W = 11;
  localparam int RET_W   = 14;
  localparam int TAG_W   = 9;

  localparam logic [1:0] LANE_U1 = 2'd0;
  localparam logic [1:0] LANE_U3 = 2'd1;
  localparam logic [1:0] LANE_U5 = 2'd2;

  typedef struct packed {
    logic [RET_W-1:0]   ret;
    logic [TAG_W-1:0]   tag;
    logic [RAISE_W-1:0] raise;
  } fpu_ret_ent_t;

  localparam int ENT_W = $bits(fpu_ret_ent_t);

  // Next lane in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] lane);
    return (lane == LANE_U5) ? LANE_U1 : lane + 2'd1;
  endfunction

endpackage

// File: rtl/fpu_ret_fifo.sv
// Single-lane result FIFO. A push into a full FIFO is still accepted when
// the head is popped in the same cycle; otherwise it is dropped and flagged.
module fpu_ret_fifo
  import fpu_ret_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [ENT_W-1:0] i_data,
  input  logic             i_pop,
  output logic [ENT_W-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_wr;

  assign w_wr    = i_push & ((r_cnt != CW'(DEPTH)) | i_pop);
  assign o_ovf   = i_push & ~w_wr;
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
      case ({w_wr, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_wr) r_mem[r_wp] <= i_data;
  end

endmodule

// File: rtl/fpu_ret_collect.sv
// Collects results from FPU lanes u1/u3/u5 and drains them one per cycle to retire.
// cmp_* is a valid/ready source: an entry transfers on a cycle with cmp_vld & cmp_rdy,
// and while cmp_vld is high and cmp_rdy low the presented entry does not change.
module fpu_ret_collect
  import fpu_ret_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [13:0]        u1_ret,
  input  logic               u1_ret_en,
  input  logic [TAGW-1:0]    u1_tag,
  input  logic [10:0]        u1_raise,
  output logic               u1_stall,
  input  logic [13:0]        u3_ret,
  input  logic               u3_ret_en,
  input  logic [TAGW-1:0]    u3_tag,
  input  logic [10:0]        u3_raise,
  output logic               u3_stall,
  input  logic [13:0]        u5_ret,
  input  logic               u5_ret_en,
  input  logic [TAGW-1:0]    u5_tag,
  input  logic [10:0]        u5_raise,
  output logic               u5_stall,
  output logic               cmp_vld,
  input  logic               cmp_rdy,
  output logic [1:0]         cmp_lane,
  output logic [13:0]        cmp_ret,
  output logic [TAGW-1:0]    cmp_tag,
  output logic [10:0]        cmp_raise,
  input  logic               flag_clr,
  output logic [10:0]        fp_flags,
  output logic [2:0]         ovf_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  fpu_ret_ent_t  w_in   [3];
  logic [ENT_W-1:0] w_head [3];
  logic [CW-1:0] w_cnt  [3];
  logic [2:0]    w_push;
  logic [2:0]    w_pop;
  logic [2:0]    w_ovf;
  logic [2:0]    w_ne;
  logic [1:0]    w_gnt;
  logic [1:0]    w_c1;
  logic [1:0]    w_c2;
  logic          w_hs;
  fpu_ret_ent_t  w_sel;

  logic [1:0]    r_rr;
  logic          r_lock;
  logic [1:0]    r_lock_lane;
  logic [10:0]   r_flags;
  logic [2:0]    r_ovf;

  assign w_in[0] = '{ret: u1_ret, tag: u1_tag, raise: u1_raise};
  assign w_in[1] = '{ret: u3_ret, tag: u3_tag, raise: u3_raise};
  assign w_in[2] = '{ret: u5_ret, tag: u5_tag, raise: u5_raise};
  assign w_push  = {u5_ret_en, u3_ret_en, u1_ret_en};

  for (genvar g = 0; g < 3; g++) begin : g_lane
    fpu_ret_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_data  (w_in[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_count (w_cnt[g]),
      .o_ovf   (w_ovf[g])
    );
    assign w_ne[g]  = (w_cnt[g] != '0);
    assign w_pop[g] = w_hs & (w_gnt == 2'(g));
  end

  // A stalled offer is pinned to its lane so a late arrival on a higher-priority
  // lane cannot swap the entry under a waiting retire unit.
  assign w_c1 = rr_next(r_rr);
  assign w_c2 = rr_next(w_c1);

  always_comb begin
    w_gnt = w_c2;
    if (r_lock)           w_gnt = r_lock_lane;
    else if (w_ne[r_rr])  w_gnt = r_rr;
    else if (w_ne[w_c1])  w_gnt = w_c1;
  end

  always_comb begin
    case (w_gnt)
      LANE_U1: w_sel = w_head[0];
      LANE_U3: w_sel = w_head[1];
      default: w_sel = w_head[2];
    endcase
  end

  assign cmp_vld   = |w_ne;
  assign w_hs      = cmp_vld & cmp_rdy;
  assign cmp_lane  = w_gnt;
  assign cmp_ret   = w_sel.ret;
  assign cmp_tag   = w_sel.tag;
  assign cmp_raise = w_sel.raise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr        <= LANE_U1;
      r_lock      <= 1'b0;
      r_lock_lane <= LANE_U1;
      r_flags     <= '0;
      r_ovf       <= '0;
    end else begin
      if (w_hs) r_rr <= rr_next(w_gnt);
      r_lock      <= cmp_vld & ~cmp_rdy;
      r_lock_lane <= w_gnt;
      r_flags     <= (flag_clr ? 11'd0 : r_flags) | (w_hs ? w_sel.raise : 11'd0);
      r_ovf       <= r_ovf | w_ovf;
    end
  end

  assign fp_flags = r_flags;
  assign ovf_err  = r_ovf;
  assign u1_stall = (w_cnt[0] >= CW'(DEPTH - 1));
  assign u3_stall = (w_cnt[1] >= CW'(DEPTH - 1));
  assign u5_stall = (w_cnt[2] >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Directed bench for fpu_ret_collect: drains are scored against an expected queue
// of {lane, ret, tag, raise} built from hand-chosen stimulus.
module tb_fpu_ret_collect;

  localparam int EW = 2 + 14 + 9 + 11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] u1_ret = '0, u3_ret = '0, u5_ret = '0;
  logic        u1_ret_en = 1'b0, u3_ret_en = 1'b0, u5_ret_en = 1'b0;
  logic [8:0]  u1_tag = '0, u3_tag = '0, u5_tag = '0;
  logic [10:0] u1_raise = '0, u3_raise = '0, u5_raise = '0;
  logic        u1_stall, u3_stall, u5_stall;
  logic        cmp_vld;
  logic        cmp_rdy = 1'b0;
  logic [1:0]  cmp_lane;
  logic [13:0] cmp_ret;
  logic [8:0]  cmp_tag;
  logic [10:0] cmp_raise;
  logic        flag_clr = 1'b0;
  logic [10:0] fp_flags;
  logic [2:0]  ovf_err;

  logic [EW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  fpu_ret_collect #(.DEPTH(4), .TAGW(9)) dut (
    .clk(clk), .rst(rst),
    .u1_ret(u1_ret), .u1_ret_en(u1_ret_en), .u1_tag(u1_tag), .u1_raise(u1_raise), .u1_stall(u1_stall),
    .u3_ret(u3_ret), .u3_ret_en(u3_ret_en), .u3_tag(u3_tag), .u3_raise(u3_raise), .u3_stall(u3_stall),
    .u5_ret(u5_ret), .u5_ret_en(u5_ret_en), .u5_tag(u5_tag), .u5_raise(u5_raise), .u5_stall(u5_stall),
    .cmp_vld(cmp_vld), .cmp_rdy(cmp_rdy), .cmp_lane(cmp_lane), .cmp_ret(cmp_ret),
    .cmp_tag(cmp_tag), .cmp_raise(cmp_raise),
    .flag_clr(flag_clr), .fp_flags(fp_flags), .ovf_err(ovf_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // driver tasks
  task automatic drive(input int lane, input logic en, input logic [13:0] ret,
                       input logic [8:0] tag, input logic [10:0] raise);
    case (lane)
      0: begin u1_ret_en = en; u1_ret = ret; u1_tag = tag; u1_raise = raise; end
      1: begin u3_ret_en = en; u3_ret = ret; u3_tag = tag; u3_raise = raise; end
      default: begin u5_ret_en = en; u5_ret = ret; u5_tag = tag; u5_raise = raise; end
    endcase
  endtask

  task automatic idle();
    u1_ret_en = 1'b0;
    u3_ret_en = 1'b0;
    u5_ret_en = 1'b0;
    flag_clr  = 1'b0;
  endtask

  function automatic logic [EW-1:0] mk(input logic [1:0] lane, input logic [13:0] ret,
                                       input logic [8:0] tag, input logic [10:0] raise);
    return {lane, ret, tag, raise};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_head(input string name);
    logic [EW-1:0] e;
    check({name, "_vld"}, 64'(cmp_vld), 64'd1);
    if (exp_q.size() == 0) begin
      check({name, "_q_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'({cmp_lane, cmp_ret, cmp_tag, cmp_raise}), 64'(e));
    end
  endtask

  initial begin
    do_reset();
    check("rst_vld", 64'(cmp_vld), 64'd0);
    check("rst_flags", 64'(fp_flags), 64'd0);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    check("rst_stall", 64'({u1_stall, u3_stall, u5_stall}), 64'd0);

    // single result on u3
    drive(1, 1'b1, 14'h0155, 9'h012, 11'h004);
    exp_q.push_back(mk(2'd1, 14'h0155, 9'h012, 11'h004));
    tick();
    idle();
    expect_head("single_head");
    cmp_rdy = 1'b1;
    tick();
    cmp_rdy = 1'b0;
    check("single_flags", 64'(fp_flags), 64'h004);
    check("single_empty", 64'(cmp_vld), 64'd0);

    // round-robin over two entries per lane
    do_reset();
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 3; k++) begin
        drive(k, 1'b1, 14'(100 + k * 2 + j), 9'(k * 16 + j), 11'(1 << (k * 2 + j)));
        exp_q.push_back(mk(2'(k), 14'(100 + k * 2 + j), 9'(k * 16 + j), 11'(1 << (k * 2 + j))));
      end
      tick();
    end
    idle();
    // rdy low: head must hold across cycles
    check("rr_hold_lane", 64'(cmp_lane), 64'd0);
    tick();
    check("rr_hold_lane2", 64'(cmp_lane), 64'd0);
    cmp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_head($sformatf("rr_drain%0d", i));
      tick();
    end
    cmp_rdy = 1'b0;
    check("rr_empty", 64'(cmp_vld), 64'd0);
    check("rr_flags", 64'(fp_flags), 64'h03f);

    // back-pressure and overflow on u1
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1'b1, 14'(i), 9'(i), 11'd0);
      if (i <= 4) exp_q.push_back(mk(2'd0, 14'(i), 9'(i), 11'd0));
      tick();
      check($sformatf("bp_stall%0d", i), 64'(u1_stall), 64'(i >= 3));
      check($sformatf("bp_ovf%0d", i), 64'(ovf_err), (i == 5) ? 64'h1 : 64'h0);
    end
    idle();
    check("bp_other_stall", 64'({u3_stall, u5_stall}), 64'd0);
    cmp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_head($sformatf("bp_drain%0d", i));
      tick();
    end
    cmp_rdy = 1'b0;
    check("bp_empty", 64'(cmp_vld), 64'd0);

    // full u5 with simultaneous push and pop
    do_reset();
    check("full_ovf_rst", 64'(ovf_err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(2, 1'b1, 14'(16'h0500 + i), 9'(9'h050 + i), 11'd0);
      exp_q.push_back(mk(2'd2, 14'(16'h0500 + i), 9'(9'h050 + i), 11'd0));
      tick();
    end
    check("full_stall", 64'(u5_stall), 64'd1);
    drive(2, 1'b1, 14'h0504, 9'h054, 11'd0);
    exp_q.push_back(mk(2'd2, 14'h0504, 9'h054, 11'd0));
    cmp_rdy = 1'b1;
    expect_head("full_pp_head");
    tick();
    idle();
    check("full_pp_ovf", 64'(ovf_err), 64'd0);
    check("full_pp_stall", 64'(u5_stall), 64'd1);
    for (int i = 0; i < 4; i++) begin
      expect_head($sformatf("full_drain%0d", i));
      tick();
    end
    cmp_rdy = 1'b0;
    check("full_empty", 64'(cmp_vld), 64'd0);

    // flag clear racing a drain
    do_reset();
    drive(0, 1'b1, 14'h0001, 9'h001, 11'h003);
    tick();
    idle();
    cmp_rdy = 1'b1;
    tick();
    cmp_rdy = 1'b0;
    check("clr_prior", 64'(fp_flags), 64'h003);
    drive(0, 1'b1, 14'h0002, 9'h002, 11'h010);
    tick();
    idle();
    flag_clr = 1'b1;
    cmp_rdy  = 1'b1;
    tick();
    flag_clr = 1'b0;
    cmp_rdy  = 1'b0;
    check("clr_race", 64'(fp_flags), 64'h010);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("clr_only", 64'(fp_flags), 64'h000);

    // reset mid-stream
    do_reset();
    drive(0, 1'b1, 14'h0070, 9'h070, 11'h001);
    drive(1, 1'b1, 14'h0071, 9'h071, 11'h002);
    drive(2, 1'b1, 14'h0072, 9'h072, 11'h004);
    tick();
    idle();
    drive(0, 1'b1, 14'h0073, 9'h073, 11'h008);
    cmp_rdy = 1'b1;
    tick();
    idle();
    cmp_rdy = 1'b0;
    check("mid_flags", 64'(fp_flags), 64'h001);
    check("mid_vld", 64'(cmp_vld), 64'd1);
    rst = 1'b0;
    drive(1, 1'b1, 14'h007f, 9'h07f, 11'h400);
    tick();
    rst = 1'b1;
    idle();
    check("mid_rst_vld", 64'(cmp_vld), 64'd0);
    check("mid_rst_flags", 64'(fp_flags), 64'd0);
    check("mid_rst_stall", 64'({u1_stall, u3_stall, u5_stall}), 64'd0);
    tick();
    check("mid_rst_noenq", 64'(cmp_vld), 64'd0);
    check("mid_rst_ovf", 64'(ovf_err), 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
